// File: rtl/zero_one_run_detector.sv
// Streaming all-zero / all-ones word monitor with saturating run counters, threshold alarms and sticky flags.
// Optional DETECT_MASK_EN adds in_mask; masked-out bits are ignored, an all-zero mask matches neither class.
module zero_one_run_detector #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RUN_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
`ifdef DETECT_MASK_EN
    input  logic [WIDTH-1:0] in_mask,
`endif
    input  logic             clear,
    output logic             out_valid,
    output logic             zero,
    output logic             one,
    output logic [CNT_W-1:0] zero_run,
    output logic [CNT_W-1:0] one_run,
    output logic             zero_alarm,
    output logic             one_alarm,
    output logic             zero_sticky,
    output logic             one_sticky
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_THRESH);

    logic             z_hit, o_hit;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d, one_q, one_d;
    logic [CNT_W-1:0] zero_run_q, zero_run_d, one_run_q, one_run_d;
    logic             zero_sticky_q, zero_sticky_d, one_sticky_q, one_sticky_d;

`ifdef DETECT_MASK_EN
    always_comb begin
        z_hit = (~|(in_data & in_mask)) & (|in_mask);
        o_hit = (&(in_data | ~in_mask)) & (|in_mask);
    end
`else
    always_comb begin
        z_hit = ~|in_data;
        o_hit = &in_data;
    end
`endif

    // Clear zeroes the base count first, so a qualifying word in the same cycle yields 1.
    function automatic logic [CNT_W-1:0] run_next(input logic [CNT_W-1:0] run,
                                                   input logic hit,
                                                   input logic clr,
                                                   input logic vld);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : run;
        if (!vld)
            return base;
        if (!hit)
            return '0;
        return (base == '1) ? base : base + CNT_W'(1);
    endfunction

    always_comb begin
        out_valid_d   = in_valid;
        zero_d        = in_valid ? z_hit : zero_q;
        one_d         = in_valid ? o_hit : one_q;
        zero_run_d    = run_next(zero_run_q, z_hit, clear, in_valid);
        one_run_d     = run_next(one_run_q,  o_hit, clear, in_valid);
        zero_sticky_d = clear ? 1'b0 : (zero_sticky_q | (zero_run_d >= THRESH));
        one_sticky_d  = clear ? 1'b0 : (one_sticky_q  | (one_run_d  >= THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            zero_q        <= 1'b0;
            one_q         <= 1'b0;
            zero_run_q    <= '0;
            one_run_q     <= '0;
            zero_sticky_q <= 1'b0;
            one_sticky_q  <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            zero_q        <= zero_d;
            one_q         <= one_d;
            zero_run_q    <= zero_run_d;
            one_run_q     <= one_run_d;
            zero_sticky_q <= zero_sticky_d;
            one_sticky_q  <= one_sticky_d;
        end
    end

    always_comb begin
        out_valid   = out_valid_q;
        zero        = zero_q;
        one         = one_q;
        zero_run    = zero_run_q;
        one_run     = one_run_q;
        zero_alarm  = (zero_run_q >= THRESH);
        one_alarm   = (one_run_q  >= THRESH);
        zero_sticky = zero_sticky_q;
        one_sticky  = one_sticky_q;
    end

endmodule

// File: tb/tb_zero_one_run_detector.sv
// Bench for zero_one_run_detector: two instances (default and CNT_W=2/RUN_THRESH=3) against a behavioural model.
// Honours DETECT_MASK_EN when defined at compile time.
module tb_zero_one_run_detector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] in_mask = '1;
    logic         clear = 1'b0;

    logic       a_ov, a_z, a_o, a_za, a_oa, a_zs, a_os;
    logic [7:0] a_zr, a_or;
    logic       b_ov, b_z, b_o, b_za, b_oa, b_zs, b_os;
    logic [1:0] b_zr, b_or;

    always #5 clk = ~clk;

    zero_one_run_detector #(.WIDTH(W), .CNT_W(8), .RUN_THRESH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef DETECT_MASK_EN
        .in_mask(in_mask),
`endif
        .clear(clear), .out_valid(a_ov), .zero(a_z), .one(a_o),
        .zero_run(a_zr), .one_run(a_or), .zero_alarm(a_za), .one_alarm(a_oa),
        .zero_sticky(a_zs), .one_sticky(a_os)
    );

    zero_one_run_detector #(.WIDTH(W), .CNT_W(2), .RUN_THRESH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef DETECT_MASK_EN
        .in_mask(in_mask),
`endif
        .clear(clear), .out_valid(b_ov), .zero(b_z), .one(b_o),
        .zero_run(b_zr), .one_run(b_or), .zero_alarm(b_za), .one_alarm(b_oa),
        .zero_sticky(b_zs), .one_sticky(b_os)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: index 0 = instance a (cap 255, thresh 4), 1 = instance b (cap 3, thresh 3).
    int cap[2]    = '{255, 3};
    int thresh[2] = '{4, 3};
    int m_zr[2]   = '{0, 0};
    int m_or[2]   = '{0, 0};
    bit m_zs[2]   = '{0, 0};
    bit m_os[2]   = '{0, 0};
    bit m_ov = 0, m_z = 0, m_o = 0;

    function automatic int next_count(int cur, bit hit, bit vld, bit clr, int lim);
        int c;
        c = clr ? 0 : cur;
        if (!vld) return c;
        if (!hit) return 0;
        return (c + 1 > lim) ? lim : c + 1;
    endfunction

    function automatic bit is_zero(logic [W-1:0] d, logic [W-1:0] m);
`ifdef DETECT_MASK_EN
        return (m != 0) && ((d & m) == 0);
`else
        return d == 0;
`endif
    endfunction

    function automatic bit is_one(logic [W-1:0] d, logic [W-1:0] m);
`ifdef DETECT_MASK_EN
        return (m != 0) && ((d | ~m) == {W{1'b1}});
`else
        return d == {W{1'b1}};
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov <= 0; m_z <= 0; m_o <= 0;
            for (int i = 0; i < 2; i++) begin
                m_zr[i] <= 0; m_or[i] <= 0; m_zs[i] <= 0; m_os[i] <= 0;
            end
        end else begin
            bit zh, oh;
            int nz, no;
            zh = is_zero(in_data, in_mask);
            oh = is_one(in_data, in_mask);
            m_ov <= in_valid;
            if (in_valid) begin
                m_z <= zh;
                m_o <= oh;
            end
            for (int i = 0; i < 2; i++) begin
                nz = next_count(m_zr[i], zh, in_valid, clear, cap[i]);
                no = next_count(m_or[i], oh, in_valid, clear, cap[i]);
                m_zr[i] <= nz;
                m_or[i] <= no;
                m_zs[i] <= !clear && (m_zs[i] || nz >= thresh[i]);
                m_os[i] <= !clear && (m_os[i] || no >= thresh[i]);
            end
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a.out_valid", a_ov, m_ov);      chk("b.out_valid", b_ov, m_ov);
            chk("a.zero", a_z, m_z);             chk("b.zero", b_z, m_z);
            chk("a.one", a_o, m_o);              chk("b.one", b_o, m_o);
            chk("a.zero_run", a_zr, m_zr[0]);    chk("b.zero_run", b_zr, m_zr[1]);
            chk("a.one_run", a_or, m_or[0]);     chk("b.one_run", b_or, m_or[1]);
            chk("a.zero_alarm", a_za, m_zr[0] >= thresh[0]);
            chk("b.zero_alarm", b_za, m_zr[1] >= thresh[1]);
            chk("a.one_alarm", a_oa, m_or[0] >= thresh[0]);
            chk("b.one_alarm", b_oa, m_or[1] >= thresh[1]);
            chk("a.zero_sticky", a_zs, m_zs[0]); chk("b.zero_sticky", b_zs, m_zs[1]);
            chk("a.one_sticky", a_os, m_os[0]);  chk("b.one_sticky", b_os, m_os[1]);
        end
    end

    // Drives one cycle of stimulus at the falling edge; returns 1 time unit after the sampling edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit c, input logic [W-1:0] m);
        @(negedge clk);
        in_valid = v; in_data = d; clear = c; in_mask = m;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; clear = 1'b0;
        #1;
        chk("rst.zero_run", a_zr, 0);
        chk("rst.out_valid", a_ov, 0);
        chk("rst.zero", a_z, 0);
        chk("rst.zero_sticky", a_zs, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [W-1:0] ALL1 = '1;

    initial begin
        #12;
        rst_n = 1'b1;
        cmp_en = 1;

        // Mid-stream reset with a run of 3 in progress
        for (int i = 0; i < 3; i++) step(1, 8'h00, 0, ALL1);
        chk("t1.run3", a_zr, 3);
        reset_pulse();
        step(1, 8'h00, 0, ALL1);
        chk("t1.zero", a_z, 1);
        chk("t1.zero_run", a_zr, 1);

        // Five zeros, threshold 4, then a mixed word
        reset_pulse();
        for (int i = 1; i <= 5; i++) begin
            step(1, 8'h00, 0, ALL1);
            chk("t2.zero_run", a_zr, i);
            chk("t2.zero_alarm", a_za, i >= 4);
        end
        chk("t2.sticky", a_zs, 1);
        step(1, 8'h5A, 0, ALL1);
        chk("t2.mixed_run", a_zr, 0);
        chk("t2.mixed_alarm", a_za, 0);
        chk("t2.sticky_hold", a_zs, 1);

        // Idle gap does not break a run
        reset_pulse();
        step(1, 8'hFF, 0, ALL1);
        chk("t3.ov1", a_ov, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, ALL1);
            chk("t3.ov_idle", a_ov, 0);
        end
        step(1, 8'hFF, 0, ALL1);
        chk("t3.ov2", a_ov, 1);
        chk("t3.one_run", a_or, 2);

        // Saturation on the CNT_W=2 instance
        reset_pulse();
        for (int i = 1; i <= 6; i++) begin
            step(1, 8'hFF, 0, ALL1);
            chk("t4.b_one_run", b_or, (i > 3) ? 3 : i);
            chk("t4.a_one_run", a_or, i);
        end

        // Clear with a concurrent valid word
        reset_pulse();
        for (int i = 0; i < 4; i++) step(1, 8'h00, 0, ALL1);
        chk("t5.sticky_set", a_zs, 1);
        step(1, 8'h00, 1, ALL1);
        chk("t5.clr_run", a_zr, 1);
        chk("t5.clr_sticky", a_zs, 0);
        step(1, 8'h12, 1, ALL1);
        chk("t5.clr_mixed_run", a_zr, 0);

`ifdef DETECT_MASK_EN
        reset_pulse();
        step(1, 8'hAF, 0, 8'h0F);
        chk("t6.one_masked", a_o, 1);
        chk("t6.one_run", a_or, 1);
        step(1, 8'hAF, 0, 8'h00);
        chk("t6.zero_m0", a_z, 0);
        chk("t6.one_m0", a_o, 0);
        chk("t6.one_run_m0", a_or, 0);
`endif

        // Randomised stream biased toward all-0/all-1 runs
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d, m;
            int sel;
            sel = $urandom_range(0, 9);
            d = (sel < 4) ? 8'h00 : (sel < 8) ? ALL1 : W'($urandom);
            m = ($urandom_range(0, 3) == 0) ? W'($urandom) : ALL1;
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 39) == 0, m);
            if ($urandom_range(0, 299) == 0) reset_pulse();
        end

        @(negedge clk);
        #1;
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
